// File: rtl/amiga_clk_altera_model_if.sv
`timescale 1ps/1ps
// Output bundle of the behavioural PLL model: four derived clocks plus the
// lock flag.
//   c0     SDRAM controller clock
//   c1     28 MHz system clock
//   c2     SDRAM pin clock (phase-shifted c0)
//   c3     50 MHz clock
//   locked high while all clocks are valid
// master: the PLL model drives the bundle; slave: consumers observe it.
interface amiga_clk_altera_model_if;
   logic c0;
   logic c1;
   logic c2;
   logic c3;
   logic locked;

   modport master (output c0, c1, c2, c3, locked);
   modport slave  (input  c0, c1, c2, c3, locked);
endinterface

// File: rtl/amiga_clk_altera_model.sv
`timescale 1ps/1ps
// Behavioural, simulation-only model of the Amiga clock PLL (time unit 1 ps).
// Measures the inclk0 period, locks after LOCK_CYCLES consecutive stable
// periods and then synthesises c0..c3 from the period captured at lock.
//   inclk0  in   reference clock, 27 MHz nominal
//   areset  in   asynchronous active-high reset
//   pll     out  c0..c3 derived clocks and the locked flag (interface, master)
// Optional feature: define AMIGA_PLL_LOSS_DETECT_EN to drop lock when inclk0
// stops for two stored periods; without it the outputs hold until areset or
// a mismatched period.
module amiga_clk_altera_model #(
   parameter int unsigned C0_MUL        = 17,
   parameter int unsigned C0_DIV        = 4,
   parameter int unsigned C1_MUL        = 227,
   parameter int unsigned C1_DIV        = 216,
   parameter int unsigned C2_MUL        = 17,
   parameter int unsigned C2_DIV        = 4,
   parameter int          C2_PHASE_MDEG = -146250,
   parameter int unsigned C3_MUL        = 50,
   parameter int unsigned C3_DIV        = 27,
   parameter int unsigned LOCK_CYCLES   = 8,
   parameter int unsigned TOL_PPM       = 1000
) (
   input  logic                            inclk0,
   input  logic                            areset,
   amiga_clk_altera_model_if.master        pll
);

   localparam int unsigned N_OUT      = 4;
   localparam int unsigned MUL_TAB [N_OUT] = '{C0_MUL, C1_MUL, C2_MUL, C3_MUL};
   localparam int unsigned DIV_TAB [N_OUT] = '{C0_DIV, C1_DIV, C2_DIV, C3_DIV};
   localparam int unsigned PHASE_MDEG =
      32'(((C2_PHASE_MDEG % 360000) + 360000) % 360000);

   typedef enum logic [1:0] {
      ST_IDLE,   // no timestamp yet
      ST_ACQ,    // measuring, counting stable periods
      ST_LOCK    // outputs running, frequencies frozen
   } state_t;

   state_t      state_q;
   logic        locked_q;
   int unsigned cnt_q;
   time         last_ts_q;
   time         tin_q;
   logic        tin_vld_q;
   time         hi_q  [N_OUT];
   time         lo_q  [N_OUT];
   time         dly_q [N_OUT];
   logic        lost;
   logic        run_c;

   function automatic time period_now();
      return $time - last_ts_q;
   endfunction

   // |p - ref_p| within TOL_PPM of ref_p
   function automatic logic in_tol(input time p, input time ref_p);
      time d;
      d = (p > ref_p) ? p - ref_p : ref_p - p;
      return (d * 64'd1_000_000) <= (64'(TOL_PPM) * ref_p);
   endfunction

   // High half = ceil(T/2), low half = floor(T/2), T = p*div/mul
   function automatic time calc_hi(input time p, input int unsigned mul, input int unsigned div);
      return (p * 64'(div) + 64'(2 * mul) - 64'd1) / 64'(2 * mul);
   endfunction

   function automatic time calc_lo(input time p, input int unsigned mul, input int unsigned div);
      return (p * 64'(div)) / 64'(2 * mul);
   endfunction

   // c2 rising-edge offset, rounded to nearest ps
   function automatic time calc_dly(input time p);
      return (p * 64'(C2_DIV) * 64'(PHASE_MDEG) + 64'(C2_MUL) * 64'd180000)
             / (64'(C2_MUL) * 64'd360000);
   endfunction

   // Period measurement and lock state, evaluated at each inclk0 rising edge
   always_ff @(posedge inclk0 or posedge areset) begin : p_lock
      if (areset) begin
         state_q   <= ST_IDLE;
         locked_q  <= 1'b0;
         cnt_q     <= '0;
         last_ts_q <= '0;
         tin_q     <= '0;
         tin_vld_q <= 1'b0;
         for (int unsigned k = 0; k < N_OUT; k++) begin
            hi_q[k]  <= '0;
            lo_q[k]  <= '0;
            dly_q[k] <= '0;
         end
      end else begin
         last_ts_q <= $time;
         unique case (state_q)
            ST_IDLE: state_q <= ST_ACQ;
            ST_ACQ: begin
               tin_q     <= period_now();
               tin_vld_q <= 1'b1;
               // The first period after reset has nothing to compare against
               // and counts as stable.
               if (tin_vld_q && !in_tol(period_now(), tin_q)) begin
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1;
                  if (cnt_q + 1 >= LOCK_CYCLES) begin
                     state_q  <= ST_LOCK;
                     locked_q <= 1'b1;
                     for (int unsigned k = 0; k < N_OUT; k++) begin
                        hi_q[k]  <= calc_hi(period_now(), MUL_TAB[k], DIV_TAB[k]);
                        lo_q[k]  <= calc_lo(period_now(), MUL_TAB[k], DIV_TAB[k]);
                        dly_q[k] <= (k == 2) ? calc_dly(period_now()) : 64'd0;
                     end
                  end
               end
            end
            ST_LOCK: begin
               tin_q <= period_now();
               if (!in_tol(period_now(), tin_q)) begin
                  state_q  <= ST_ACQ;
                  locked_q <= 1'b0;
                  cnt_q    <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef AMIGA_PLL_LOSS_DETECT_EN
   // Input-loss watchdog: sleeps until two stored periods after the latest
   // edge; a newer edge pushes the deadline out and the loop re-arms.
   always begin : p_loss
      lost = 1'b0;
      wait (locked_q);
      while (locked_q && !lost) begin
         if ($time >= last_ts_q + 2 * tin_q) lost = 1'b1;
         else #(last_ts_q + 2 * tin_q - $time);
      end
      wait (!locked_q);
   end
`else
   assign lost = 1'b0;
`endif

   assign run_c = locked_q & ~lost;

   // One free-running generator per output, started by the lock edge. A
   // generator asleep at unlock exits on its next wake-up; relock needs at
   // least LOCK_CYCLES input periods, longer than any half period here.
   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      logic clk_r;
      always begin : p_gen
         clk_r = 1'b0;
         wait (locked_q);
         if (dly_q[k] != 0) #(dly_q[k]);
         while (locked_q) begin
            clk_r = 1'b1;
            #(hi_q[k]);
            if (!locked_q) break;
            clk_r = 1'b0;
            #(lo_q[k]);
         end
      end
   end

   // Gating by the lock state gives the zero-delay stop on reset/unlock.
   assign pll.c0     = g_out[0].clk_r & run_c;
   assign pll.c1     = g_out[1].clk_r & run_c;
   assign pll.c2     = g_out[2].clk_r & run_c;
   assign pll.c3     = g_out[3].clk_r & run_c;
   assign pll.locked = run_c;

endmodule

// File: tb/tb_amiga_clk_altera_model.sv
`timescale 1ps/1ps
module tb_amiga_clk_altera_model;

   logic inclk0 = 1'b0;
   logic areset = 1'b1;

   amiga_clk_altera_model_if pll ();

   amiga_clk_altera_model dut (
      .inclk0 (inclk0),
      .areset (areset),
      .pll    (pll)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input longint got, input longint exp, input longint tol);
      longint d;
      n_chk++;
      d = got - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
      end
   endtask

   // Reference clock with adjustable halves; edge times logged by index
   time         half_hi = 18519;
   time         half_lo = 18518;
   bit          clk_run = 1'b1;
   int unsigned n_edges = 0;
   time         e_t [0:1023];

   always begin
      if (clk_run) begin
         n_edges++;
         e_t[n_edges[9:0]] = $time;
         inclk0 = 1'b1;
         #(half_hi);
         inclk0 = 1'b0;
         #(half_lo);
      end else begin
         #1000;
      end
   end

   // Edge monitors on the derived clocks
   wire [3:0] cv;
   assign cv = {pll.c3, pll.c2, pll.c1, pll.c0};

   for (genvar k = 0; k < 4; k++) begin : g_mon
      time         r_first = 0;
      time         r_last  = 0;
      time         r_prev  = 0;
      time         f_last  = 0;
      int unsigned n_rise  = 0;
      always @(posedge cv[k]) begin
         if (n_rise == 0) r_first = $time;
         r_prev = r_last;
         r_last = $time;
         n_rise++;
      end
      always @(negedge cv[k]) f_last = $time;
   end

   time lk_rise_t = 0;
   time lk_fall_t = 0;
   always @(posedge pll.locked) lk_rise_t = $time;
   always @(negedge pll.locked) lk_fall_t = $time;

   task automatic chk_clk(input string tag, input time rl, input time rp, input time fl,
                          input longint exp_per, input longint exp_hi);
      time hi;
      hi = (fl > rl) ? fl - rl : fl - rp;
      check({tag, "_period"}, 64'(rl - rp), exp_per, 1);
      check({tag, "_high"}, 64'(hi), exp_hi, 1);
   endtask

   function automatic longint rises_all();
      return 64'(g_mon[0].n_rise + g_mon[1].n_rise + g_mon[2].n_rise + g_mon[3].n_rise);
   endfunction

   initial begin : p_watchdog
      #20_000_000;
      $display("FAIL watchdog: simulation did not complete by %0t", $time);
      $fatal(1);
   end

   initial begin : p_main
      int unsigned base;
      int unsigned k;
      longint      rises0;
      time         t_rst;
      time         t_last;

      // Reset state
      #50000;
      check("reset_outputs", 64'({pll.locked, cv}), 0, 0);
      #50000;
      areset = 1'b0;
      base   = n_edges;

      // Acquisition: no lock and no clock activity through edge 8
      wait (n_edges == base + 8);
      #1000;
      check("prelock_locked", 64'(pll.locked), 0, 0);
      check("prelock_rises", rises_all(), 0, 0);

      // Lock on edge 9
      wait (n_edges == base + 9);
      #1;
      check("lock_edge9", 64'(pll.locked), 1, 0);
      check("lock_time", 64'(lk_rise_t), 64'(e_t[base + 9]), 0);
      check("c0_align", 64'(g_mon[0].r_first), 64'(e_t[base + 9]), 0);
      check("c3_align", 64'(g_mon[3].r_first), 64'(e_t[base + 9]), 0);

      // Locked frequencies, duty cycle and c2 phase
      #300000;
      chk_clk("c0", g_mon[0].r_last, g_mon[0].r_prev, g_mon[0].f_last, 8715, 4358);
      chk_clk("c1", g_mon[1].r_last, g_mon[1].r_prev, g_mon[1].f_last, 35242, 17621);
      chk_clk("c2", g_mon[2].r_last, g_mon[2].r_prev, g_mon[2].f_last, 8715, 4358);
      chk_clk("c3", g_mon[3].r_last, g_mon[3].r_prev, g_mon[3].f_last, 20000, 10000);
      check("c2_lag", 64'(g_mon[2].r_first - g_mon[0].r_first), 5175, 2);

      // areset 3 us after lock: everything low at once, no activity held in reset
      #(lk_rise_t + 64'd3000000 - $time);
      t_rst  = $time;
      areset = 1'b1;
      #1;
      check("rst_locked_time", 64'(lk_fall_t), 64'(t_rst), 0);
      check("rst_outputs", 64'({pll.locked, cv}), 0, 0);
      rises0 = rises_all();
      #200000;
      check("rst_no_rises", rises_all(), rises0, 0);
      areset = 1'b0;
      base   = n_edges;
      wait (n_edges == base + 8);
      #1000;
      check("relock_pre", 64'(pll.locked), 0, 0);
      wait (n_edges == base + 9);
      #1;
      check("relock_edge9", 64'(pll.locked), 1, 0);
      check("relock_time", 64'(lk_rise_t), 64'(e_t[base + 9]), 0);

      // Period change to 40000 ps, applied in the low phase so edge base+2 is the first long one
      #200000;
      k = n_edges;
      wait (n_edges == k + 1);
      #25000;
      half_hi = 20000;
      half_lo = 20000;
      base    = n_edges;
      wait (n_edges == base + 2);
      #1;
      check("chg_unlock", 64'(pll.locked), 0, 0);
      check("chg_unlock_time", 64'(lk_fall_t), 64'(e_t[base + 2]), 0);
      check("chg_outputs", 64'(cv), 0, 0);
      wait (n_edges == base + 9);
      #1000;
      check("chg_prelock", 64'(pll.locked), 0, 0);
      wait (n_edges == base + 10);
      #1;
      check("chg_relock_time", 64'(lk_rise_t), 64'(e_t[base + 10]), 0);
      #200000;
      chk_clk("c0_40k", g_mon[0].r_last, g_mon[0].r_prev, g_mon[0].f_last, 9412, 4706);

      // Input stops after an edge
      k = n_edges;
      wait (n_edges == k + 1);
      #25000;
      clk_run = 1'b0;
      t_last  = e_t[k + 1];
      #200000;
`ifdef AMIGA_PLL_LOSS_DETECT_EN
      check("loss_locked", 64'(pll.locked), 0, 0);
      check("loss_time", 64'(lk_fall_t), 64'(t_last + 64'd80000), 0);
      check("loss_outputs", 64'(cv), 0, 0);
`else
      check("stop_hold_locked", 64'(pll.locked), 1, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
